// File: rtl/rca_multiword_sequencer_if.sv
// Start/busy/done handshake and operand/result bus of the multi-word sequencer.
// The controller drives the master side and the sequencer is the slave.
interface rca_multiword_sequencer_if #(
    parameter int WORDS = 4
) ();
    localparam int W = 16 * WORDS;

    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c0;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         c;

    modport master (output start, op, a, b, c0, input busy, done, s, c);
    modport slave  (input start, op, a, b, c0, output busy, done, s, c);
endinterface

// File: rtl/rca_multiword_sequencer.sv
// Multi-precision add/subtract over WORDS 16-bit slices, LSB first, reusing one
// 16-bit ripple-carry adder. The carry is chained between slices through a register.
module RCA_16Bit_Adder (
    output logic [15:0] s,
    output logic        c,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c0
);
    always_comb begin : chain
        logic [16:0] cy;
        cy    = '0;
        s     = '0;
        cy[0] = c0;
        for (int i = 0; i < 16; i++) begin
            s[i]     = a[i] ^ b[i] ^ cy[i];
            cy[i+1]  = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
        end
        c = cy[16];
    end
endmodule

module rca_multiword_sequencer #(
    parameter int WORDS = 4,
    parameter int IDXW  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    rca_multiword_sequencer_if.slave     bus
);
    localparam int W = 16 * WORDS;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    acc_upd;
    logic [W-1:0]    s_q;
    logic            op_q;
    logic            carry_q;
    logic            c_q;
    logic [IDXW-1:0] idx_q;
    logic [15:0]     a_sl;
    logic [15:0]     b_sl;
    logic [15:0]     b_eff;
    logic [15:0]     sum;
    logic            sum_c;
    logic            last;
    logic            busy;
    logic            done;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (bus.start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Slice select by constant-index compare keeps the mux free of wide index math.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_sl = a_q[16*i +: 16];
                b_sl = b_q[16*i +: 16];
            end
        end
    end

    assign b_eff = op_q ? ~b_sl : b_sl;
    assign last  = (idx_q == IDXW'(WORDS - 1));

    RCA_16Bit_Adder u_rca (
        .s  (sum),
        .c  (sum_c),
        .a  (a_sl),
        .b  (b_eff),
        .c0 (carry_q)
    );

    always_comb begin
        acc_upd = acc_q;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDXW'(i)) acc_upd[16*i +: 16] = sum;
        end
    end

    // s/c only change on the final slice so the controller never sees partial sums.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        op_q    <= bus.op;
                        carry_q <= bus.op | bus.c0;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    acc_q   <= acc_upd;
                    carry_q <= sum_c;
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        s_q <= acc_upd;
                        c_q <= sum_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.s    = s_q;
    assign bus.c    = c_q;
endmodule
